// File: rtl/noc_level_link.sv
// Inter-level NoC link: delayed forward and credit paths, sender-side credit accounting,
// and a drain/quiesce FSM that lets topology control prove the level is empty.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   in_vc_target/in_packet    sender flits (VC one-hot-or-zero per channel)
//   in_vc_credit_gnt          credits handed back to the sender, LATENCY cycles late
//   out_vc_target/out_packet  flits to the receiver, LATENCY cycles late
//   out_vc_credit_gnt         credits from the receiver
//   drain_req                 hold-off request from topology control
//   quiesced                  drain complete, link empty
//   credit_err                sticky per-channel protocol error
//   credits_home              every VC counter is full
module noc_level_link #(
    parameter int CHANNELS      = 8,
    parameter int VC_W          = 2,
    parameter int A_W           = 4,
    parameter int D_W           = 32,
    parameter int LATENCY       = 1,
    parameter int VC_FIFO_DEPTH = 4,
    localparam int PKT_W        = A_W + D_W,
    localparam int CW           = $clog2(VC_FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*VC_W-1:0]  in_vc_target,
    input  logic [CHANNELS*PKT_W-1:0] in_packet,
    output logic [CHANNELS*VC_W-1:0]  in_vc_credit_gnt,
    output logic [CHANNELS*VC_W-1:0]  out_vc_target,
    output logic [CHANNELS*PKT_W-1:0] out_packet,
    input  logic [CHANNELS*VC_W-1:0]  out_vc_credit_gnt,
    input  logic                      drain_req,
    output logic                      quiesced,
    output logic [CHANNELS-1:0]       credit_err,
    output logic                      credits_home
);

    localparam int VN = CHANNELS * VC_W;
    localparam int PN = CHANNELS * PKT_W;
    localparam logic [CW-1:0] CMAX = CW'(VC_FIFO_DEPTH - 1);

    logic pipe_empty;

    if (LATENCY == 0) begin : g_comb
        assign out_vc_target    = in_vc_target;
        assign out_packet       = in_packet;
        assign in_vc_credit_gnt = out_vc_credit_gnt;
        assign pipe_empty       = 1'b1;
    end else begin : g_pipe
        logic [VN-1:0] tgt_q [LATENCY];
        logic [PN-1:0] pkt_q [LATENCY];
        logic [VN-1:0] crd_q [LATENCY];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < LATENCY; i++) begin
                    tgt_q[i] <= '0;
                    pkt_q[i] <= '0;
                    crd_q[i] <= '0;
                end
            end else begin
                tgt_q[0] <= in_vc_target;
                pkt_q[0] <= in_packet;
                crd_q[0] <= out_vc_credit_gnt;
                for (int i = 1; i < LATENCY; i++) begin
                    tgt_q[i] <= tgt_q[i-1];
                    pkt_q[i] <= pkt_q[i-1];
                    crd_q[i] <= crd_q[i-1];
                end
            end
        end

        assign out_vc_target    = tgt_q[LATENCY-1];
        assign out_packet       = pkt_q[LATENCY-1];
        assign in_vc_credit_gnt = crd_q[LATENCY-1];

        // Only the VC bits matter: packet bits are don't-care without a valid.
        always_comb begin
            pipe_empty = 1'b1;
            for (int i = 0; i < LATENCY; i++) begin
                if ((|tgt_q[i]) || (|crd_q[i])) begin
                    pipe_empty = 1'b0;
                end
            end
        end
    end

    // A channel driving more than one VC at once is malformed.
    logic [CHANNELS-1:0] multi;
    for (genvar c = 0; c < CHANNELS; c++) begin : g_mh
        logic [VC_W-1:0] t;
        assign t        = in_vc_target[c*VC_W +: VC_W];
        assign multi[c] = |(t & (t - VC_W'(1)));
    end

    logic [CW-1:0]       cnt_q [CHANNELS][VC_W];
    logic [CW-1:0]       cnt_d [CHANNELS][VC_W];
    logic [CHANNELS-1:0] err_q;
    logic [CHANNELS-1:0] err_d;

    // Flit and credit together cancel; a lone flit at 0 or a lone
    // credit at max flags the channel and saturates the counter.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (multi[c]) begin
                err_d[c] = 1'b1;
            end else begin
                for (int v = 0; v < VC_W; v++) begin
                    if (in_vc_target[c*VC_W+v] && !in_vc_credit_gnt[c*VC_W+v]) begin
                        if (cnt_q[c][v] == '0) err_d[c] = 1'b1;
                        else cnt_d[c][v] = cnt_q[c][v] - CW'(1);
                    end else if (in_vc_credit_gnt[c*VC_W+v] && !in_vc_target[c*VC_W+v]) begin
                        if (cnt_q[c][v] == CMAX) err_d[c] = 1'b1;
                        else cnt_d[c][v] = cnt_q[c][v] + CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int v = 0; v < VC_W; v++) begin
                    cnt_q[c][v] <= CMAX;
                end
            end
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        credits_home = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int v = 0; v < VC_W; v++) begin
                if (cnt_q[c][v] != CMAX) credits_home = 1'b0;
            end
        end
    end

    assign credit_err = err_q;

    typedef enum logic [1:0] {RUN, DRAIN, QUIESCED} state_e;

    state_e state_q;
    logic   quiesced_q;
    logic   any_flit;

    assign any_flit = |in_vc_target;

    // Dropping drain_req wins over completing the drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            quiesced_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (drain_req) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!drain_req) begin
                        state_q <= RUN;
                    end else if (credits_home && pipe_empty && !any_flit) begin
                        state_q    <= QUIESCED;
                        quiesced_q <= 1'b1;
                    end
                end
                QUIESCED: begin
                    if (!drain_req) begin
                        state_q    <= RUN;
                        quiesced_q <= 1'b0;
                    end else if (any_flit) begin
                        state_q    <= DRAIN;
                        quiesced_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    quiesced_q <= 1'b0;
                end
            endcase
        end
    end

    assign quiesced = quiesced_q;

endmodule

// File: tb/tb_noc_level_link.sv
// Bench for noc_level_link: four instances (LATENCY 0..3) share one stimulus
// and are checked every cycle against a queue/arithmetic reference model.
module tb_noc_level_link;

    localparam int CH  = 8;
    localparam int VC  = 2;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int PW  = AW + DW;
    localparam int DEP = 4;
    localparam int NL  = 4;
    localparam int VN  = CH * VC;
    localparam int PN  = CH * PW;

    typedef logic [VN-1:0] v_t;
    typedef logic [PN-1:0] p_t;

    typedef struct {
        int            ch;
        logic [VC-1:0] t;
        logic [VC-1:0] c;
        logic [CH-1:0] err;
    } vec_t;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    v_t   in_t  = '0;
    v_t   out_cg = '0;
    p_t   in_p  = '0;
    logic drain = 1'b0;

    v_t            d_cg   [NL];
    v_t            d_ot   [NL];
    p_t            d_op   [NL];
    logic          d_q    [NL];
    logic [CH-1:0] d_err  [NL];
    logic          d_home [NL];

    int checks = 0;
    int fails  = 0;

    v_t            mt [NL][$];
    p_t            mp [NL][$];
    v_t            mc [NL][$];
    int            cnt [NL][CH][VC];
    logic [CH-1:0] merr [NL];
    int            mst [NL];
    int            rx [CH][VC];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NL; k++) begin : g_dut
        noc_level_link #(
            .CHANNELS(CH), .VC_W(VC), .A_W(AW), .D_W(DW),
            .LATENCY(k), .VC_FIFO_DEPTH(DEP)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .in_vc_target(in_t),
            .in_packet(in_p),
            .in_vc_credit_gnt(d_cg[k]),
            .out_vc_target(d_ot[k]),
            .out_packet(d_op[k]),
            .out_vc_credit_gnt(out_cg),
            .drain_req(drain),
            .quiesced(d_q[k]),
            .credit_err(d_err[k]),
            .credits_home(d_home[k])
        );
    end

    task automatic chk(input string nm, input p_t act, input p_t exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic v_t e_t(int k);
        if (k == 0) return in_t;
        return mt[k][0];
    endfunction

    function automatic p_t e_p(int k);
        if (k == 0) return in_p;
        return mp[k][0];
    endfunction

    function automatic v_t e_c(int k);
        if (k == 0) return out_cg;
        return mc[k][0];
    endfunction

    function automatic logic m_home(int k);
        for (int c = 0; c < CH; c++)
            for (int v = 0; v < VC; v++)
                if (cnt[k][c][v] != DEP - 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NL; k++) begin
            mt[k].delete();
            mp[k].delete();
            mc[k].delete();
            for (int i = 0; i < k; i++) begin
                mt[k].push_back('0);
                mp[k].push_back('0);
                mc[k].push_back('0);
            end
            merr[k] = '0;
            mst[k]  = 0;
            for (int c = 0; c < CH; c++)
                for (int v = 0; v < VC; v++)
                    cnt[k][c][v] = DEP - 1;
        end
        for (int c = 0; c < CH; c++)
            for (int v = 0; v < VC; v++)
                rx[c][v] = 0;
    endfunction

    task automatic check_all(input int k);
        chk($sformatf("out_vc_target L%0d", k), d_ot[k], e_t(k));
        chk($sformatf("out_packet L%0d", k), d_op[k], e_p(k));
        chk($sformatf("in_vc_credit_gnt L%0d", k), d_cg[k], e_c(k));
        chk($sformatf("credit_err L%0d", k), d_err[k], merr[k]);
        chk($sformatf("credits_home L%0d", k), d_home[k], m_home(k));
        chk($sformatf("quiesced L%0d", k), d_q[k], mst[k] == 2);
    endtask

    // State 0 = RUN, 1 = DRAIN, 2 = QUIESCED.
    function automatic void model_step();
        for (int k = 0; k < NL; k++) begin
            v_t   g     = e_c(k);
            logic home  = m_home(k);
            logic empty = 1'b1;
            for (int i = 0; i < k; i++)
                if (mt[k][i] != '0 || mc[k][i] != '0) empty = 1'b0;
            for (int c = 0; c < CH; c++) begin
                logic [VC-1:0] tv = in_t[c*VC +: VC];
                if ($countones(tv) > 1) begin
                    merr[k][c] = 1'b1;
                end else begin
                    for (int v = 0; v < VC; v++) begin
                        int n = cnt[k][c][v] + int'(g[c*VC+v]) - int'(tv[v]);
                        if (n < 0) begin
                            merr[k][c] = 1'b1;
                            n = 0;
                        end else if (n > DEP - 1) begin
                            merr[k][c] = 1'b1;
                            n = DEP - 1;
                        end
                        cnt[k][c][v] = n;
                    end
                end
            end
            case (mst[k])
                0: if (drain) mst[k] = 1;
                1: begin
                    if (!drain) mst[k] = 0;
                    else if (home && empty && in_t == '0) mst[k] = 2;
                end
                default: begin
                    if (!drain) mst[k] = 0;
                    else if (in_t != '0) mst[k] = 1;
                end
            endcase
            if (k > 0) begin
                mt[k].push_back(in_t);
                mp[k].push_back(in_p);
                mc[k].push_back(out_cg);
                void'(mt[k].pop_front());
                void'(mp[k].pop_front());
                void'(mc[k].pop_front());
            end
        end
    endfunction

    task automatic tick();
        #1;
        for (int k = 0; k < NL; k++) check_all(k);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_t   = '0;
        out_cg = '0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < NL; k++) check_all(k);
        in_t   = '0;
        out_cg = '0;
        in_p   = '0;
        drain  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic rand_inputs();
        v_t a = mt[NL-1][0];
        in_t   = '0;
        out_cg = '0;
        for (int i = 0; i < PN / 32; i++) in_p[i*32 +: 32] = $urandom;
        for (int c = 0; c < CH; c++)
            for (int v = 0; v < VC; v++)
                if (a[c*VC+v]) rx[c][v]++;
        for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int v = $urandom_range(0, VC - 1);
                int m = DEP;
                for (int k = 0; k < NL; k++)
                    if (cnt[k][c][v] < m) m = cnt[k][c][v];
                if (m > 0) in_t[c*VC+v] = 1'b1;
            end
        end
        for (int c = 0; c < CH; c++)
            for (int v = 0; v < VC; v++)
                if (rx[c][v] > 0 && $urandom_range(0, 1) == 1) begin
                    out_cg[c*VC+v] = 1'b1;
                    rx[c][v]--;
                end
        if ($urandom_range(0, 19) == 0) drain = ~drain;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [13];
        tbl[0]  = '{0, 2'b01, 2'b00, 8'h00};
        tbl[1]  = '{0, 2'b01, 2'b00, 8'h00};
        tbl[2]  = '{0, 2'b01, 2'b00, 8'h00};
        tbl[3]  = '{0, 2'b01, 2'b00, 8'h01};
        tbl[4]  = '{1, 2'b10, 2'b00, 8'h01};
        tbl[5]  = '{1, 2'b10, 2'b00, 8'h01};
        tbl[6]  = '{1, 2'b10, 2'b00, 8'h01};
        tbl[7]  = '{1, 2'b10, 2'b10, 8'h01};
        tbl[8]  = '{1, 2'b00, 2'b10, 8'h01};
        tbl[9]  = '{1, 2'b00, 2'b10, 8'h01};
        tbl[10] = '{1, 2'b00, 2'b10, 8'h01};
        tbl[11] = '{1, 2'b00, 2'b10, 8'h03};
        tbl[12] = '{2, 2'b11, 2'b00, 8'h07};

        // Reset state.
        model_reset();
        @(negedge clk);
        #1;
        for (int k = 0; k < NL; k++) check_all(k);
        chk("reset out_vc_target L3", d_ot[3], '0);
        chk("reset credits_home L3", d_home[3], 1'b1);
        chk("reset quiesced L3", d_q[3], 1'b0);
        rst = 1'b1;
        idle(2);

        // Credit accounting vectors, expectations for the pass-through link.
        for (int i = 0; i < 13; i++) begin
            in_t   = '0;
            out_cg = '0;
            in_t[tbl[i].ch*VC +: VC]   = tbl[i].t;
            out_cg[tbl[i].ch*VC +: VC] = tbl[i].c;
            tick();
            chk($sformatf("tbl%0d credit_err L0", i), d_err[0], tbl[i].err);
        end
        idle(4);
        do_reset();

        // Single flit on ch3 vc1 through each latency.
        in_t = '0;
        in_t[3*VC+1] = 1'b1;
        in_p = '0;
        in_p[3*PW +: PW] = 36'h9DEADBEEF;
        #1;
        chk("t1 L0 same-cycle target", d_ot[0][3*VC+1], 1'b1);
        chk("t1 L0 same-cycle packet", d_op[0][3*PW +: PW], 36'h9DEADBEEF);
        tick();
        in_t = '0;
        in_p = '0;
        #1;
        chk("t1 L2 not yet", d_ot[2][3*VC+1], 1'b0);
        chk("t1 L2 credit taken", d_home[2], 1'b0);
        tick();
        #1;
        chk("t1 L2 arrives", d_ot[2][3*VC+1], 1'b1);
        chk("t1 L2 packet", d_op[2][3*PW +: PW], 36'h9DEADBEEF);
        tick();
        out_cg[3*VC+1] = 1'b1;
        tick();
        idle(4);
        chk("t1 L2 credit home", d_home[2], 1'b1);

        // Drain with two credits outstanding.
        do_reset();
        in_t = '0;
        in_t[0] = 1'b1;
        tick();
        tick();
        in_t  = '0;
        drain = 1'b1;
        idle(5);
        chk("t4 L1 waiting", d_q[1], 1'b0);
        out_cg[0] = 1'b1;
        tick();
        idle(4);
        chk("t4 L1 one outstanding", d_q[1], 1'b0);
        out_cg[0] = 1'b1;
        tick();
        out_cg = '0;
        #1;
        chk("t4 L1 credit in pipe", d_q[1], 1'b0);
        chk("t4 L0 condition cycle", d_q[0], 1'b0);
        tick();
        #1;
        chk("t4 L1 condition cycle", d_q[1], 1'b0);
        chk("t4 L0 quiesced", d_q[0], 1'b1);
        tick();
        #1;
        chk("t4 L1 quiesced", d_q[1], 1'b1);
        idle(3);
        chk("t4 L3 quiesced", d_q[3], 1'b1);
        drain = 1'b0;
        #1;
        chk("t4 L1 held", d_q[1], 1'b1);
        tick();
        #1;
        chk("t4 L1 released", d_q[1], 1'b0);
        chk("t4 L0 released", d_q[0], 1'b0);

        // Flit while quiesced re-opens the drain.
        drain = 1'b1;
        idle(4);
        chk("t5 L1 quiesced", d_q[1], 1'b1);
        in_t = '0;
        in_t[5*VC] = 1'b1;
        #1;
        chk("t5 L1 still quiesced", d_q[1], 1'b1);
        tick();
        in_t = '0;
        #1;
        chk("t5 L1 back to drain", d_q[1], 1'b0);
        chk("t5 L1 flit delivered", d_ot[1][5*VC], 1'b1);
        idle(3);
        chk("t5 L1 credit away", d_q[1], 1'b0);
        out_cg[5*VC] = 1'b1;
        tick();
        idle(3);
        chk("t5 L1 requiesced", d_q[1], 1'b1);
        drain = 1'b0;
        idle(2);

        // Randomised credit-respecting traffic.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            tick();
        end

        // Asynchronous reset in the middle of traffic.
        rand_inputs();
        #3;
        rst = 1'b0;
        #1;
        chk("t6 L3 out_vc_target", d_ot[3], '0);
        chk("t6 L3 out_packet", d_op[3], '0);
        chk("t6 L3 credit_gnt", d_cg[3], '0);
        chk("t6 L3 credits_home", d_home[3], 1'b1);
        chk("t6 L3 credit_err", d_err[3], '0);
        chk("t6 L3 quiesced", d_q[3], 1'b0);
        model_reset();
        for (int k = 0; k < NL; k++) check_all(k);
        in_t   = '0;
        out_cg = '0;
        in_p   = '0;
        drain  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
